// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding controller for a 5-stage pipeline with I/D caches.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
    parameter int REG_W        = 4,
    parameter int NUM_SRC      = 2,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*REG_W-1:0] fd_src,
    input  logic [NUM_SRC-1:0]       fd_src_vld,
    input  logic [NUM_SRC-1:0]       fd_src_mm_ok,
    input  logic [NUM_SRC*REG_W-1:0] dx_src,
    input  logic [REG_W-1:0]         dx_rd,
    input  logic                     dx_memread,
    input  logic [REG_W-1:0]         xm_rd,
    input  logic [REG_W-1:0]         xm_rt,
    input  logic                     xm_regwrite,
    input  logic                     xm_memwrite,
    input  logic [REG_W-1:0]         mw_rd,
    input  logic                     mw_regwrite,
    input  logic                     dcache_stall,
    input  logic                     icache_stall,
    output logic [2*NUM_SRC-1:0]     fwd_sel,
    output logic                     fwd_mm,
    output logic                     freeze,
    output logic                     stall_fd,
    output logic                     bubble_dx,
    output logic                     bubble_fd,
    output logic [1:0]               state,
    output logic                     miss_err,
    output logic [CNT_W-1:0]         ldu_cnt,
    output logic [CNT_W-1:0]         dmiss_cnt,
    output logic [CNT_W-1:0]         imiss_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LDUSE = 2'b01,
        ST_DMISS = 2'b10,
        ST_IMISS = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MISS_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_nxt;
    logic             ldu;
    logic             xm_fwd_ok;
    logic             mw_fwd_ok;

    // Register 0 never carries a real result, so it is excluded as a source.
    assign xm_fwd_ok = xm_regwrite && (xm_rd != '0);
    assign mw_fwd_ok = mw_regwrite && (mw_rd != '0);

    function automatic logic [1:0] fwd_code(input logic [REG_W-1:0] src);
        if (xm_fwd_ok && (xm_rd == src))
            return 2'b01;
        else if (mw_fwd_ok && (mw_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fwd_sel = '0;
        if (rst_n) begin
            for (int i = 0; i < NUM_SRC; i++)
                fwd_sel[2*i +: 2] = fwd_code(dx_src[i*REG_W +: REG_W]);
        end
    end

    always_comb begin
        ldu = 1'b0;
        if (dx_memread && (dx_rd != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fd_src_vld[i] && !fd_src_mm_ok[i] && (fd_src[i*REG_W +: REG_W] == dx_rd))
                    ldu = 1'b1;
            end
        end
    end

    assign fwd_mm    = rst_n && xm_memwrite && mw_fwd_ok && (mw_rd == xm_rt);

    // A pending load-use hazard is held off by freeze and acted on once the D-miss clears.
    assign freeze    = rst_n && dcache_stall;
    assign bubble_dx = rst_n && !dcache_stall && ldu;
    assign bubble_fd = rst_n && !dcache_stall && !ldu && icache_stall;
    assign stall_fd  = bubble_dx || bubble_fd;

    always_comb begin
        state_d = ST_RUN;
        if (dcache_stall)
            state_d = ST_DMISS;
        else if (ldu)
            state_d = ST_LDUSE;
        else if (icache_stall)
            state_d = ST_IMISS;
    end

    always_comb begin
        wd_nxt = '0;
        if (dcache_stall)
            wd_nxt = (wd_cnt >= TIMEOUT) ? TIMEOUT : wd_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            wd_cnt   <= '0;
            miss_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_cnt   <= wd_nxt;
            if (wd_nxt == TIMEOUT)
                miss_err <= 1'b1;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ldu_cnt   <= '0;
            dmiss_cnt <= '0;
            imiss_cnt <= '0;
        end else begin
            ldu_cnt   <= sat_inc(ldu_cnt,   state_d == ST_LDUSE);
            dmiss_cnt <= sat_inc(dmiss_cnt, state_d == ST_DMISS);
            imiss_cnt <= sat_inc(imiss_cnt, state_d == ST_IMISS);
        end
    end
`else
    assign ldu_cnt   = '0;
    assign dmiss_cnt = '0;
    assign imiss_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: per-cycle reference model plus directed literal checks.
module tb_hazard_fwd_ctrl;
    localparam int REG_W   = 4;
    localparam int NUM_SRC = 3;
    localparam int CNT_W   = 16;
    localparam int TO      = 8;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_SRC*REG_W-1:0] fd_src, dx_src;
    logic [NUM_SRC-1:0]       fd_src_vld, fd_src_mm_ok;
    logic [REG_W-1:0]         dx_rd, xm_rd, xm_rt, mw_rd;
    logic                     dx_memread, xm_regwrite, xm_memwrite, mw_regwrite;
    logic                     dcache_stall, icache_stall;
    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic                     fwd_mm, freeze, stall_fd, bubble_dx, bubble_fd, miss_err;
    logic [1:0]               state;
    logic [CNT_W-1:0]         ldu_cnt, dmiss_cnt, imiss_cnt;

    hazard_fwd_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .MISS_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fd_src(fd_src), .fd_src_vld(fd_src_vld),
        .fd_src_mm_ok(fd_src_mm_ok), .dx_src(dx_src), .dx_rd(dx_rd), .dx_memread(dx_memread),
        .xm_rd(xm_rd), .xm_rt(xm_rt), .xm_regwrite(xm_regwrite), .xm_memwrite(xm_memwrite),
        .mw_rd(mw_rd), .mw_regwrite(mw_regwrite), .dcache_stall(dcache_stall),
        .icache_stall(icache_stall), .fwd_sel(fwd_sel), .fwd_mm(fwd_mm), .freeze(freeze),
        .stall_fd(stall_fd), .bubble_dx(bubble_dx), .bubble_fd(bubble_fd), .state(state),
        .miss_err(miss_err), .ldu_cnt(ldu_cnt), .dmiss_cnt(dmiss_cnt), .imiss_cnt(imiss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: state cause and counters kept as plain integers.
    int m_state, m_wd, m_ldu, m_dmiss, m_imiss;
    bit m_err;

    function automatic bit model_ldu();
        if (!dx_memread || dx_rd == 0) return 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (fd_src_vld[i] && !fd_src_mm_ok[i] && fd_src[i*REG_W +: REG_W] == dx_rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_wd = 0; m_err = 0; m_ldu = 0; m_dmiss = 0; m_imiss = 0;
        end else begin
            if (dcache_stall)      m_state = 2;
            else if (model_ldu())  m_state = 1;
            else if (icache_stall) m_state = 3;
            else                   m_state = 0;
            m_wd = dcache_stall ? sat(m_wd, TO) : 0;
            if (m_wd == TO) m_err = 1;
            if (PERF) begin
                if (m_state == 1) m_ldu   = sat(m_ldu, CNT_MAX);
                if (m_state == 2) m_dmiss = sat(m_dmiss, CNT_MAX);
                if (m_state == 3) m_imiss = sat(m_imiss, CNT_MAX);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [2*NUM_SRC-1:0] e_fwd;
            bit e_mm, e_frz, e_bdx, e_bfd, hz;
            e_fwd = '0;
            e_mm = 0; e_frz = 0; e_bdx = 0; e_bfd = 0;
            if (rst_n) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    int s;
                    s = int'(dx_src[i*REG_W +: REG_W]);
                    if (xm_regwrite && xm_rd != 0 && int'(xm_rd) == s)      e_fwd[2*i +: 2] = 2'd1;
                    else if (mw_regwrite && mw_rd != 0 && int'(mw_rd) == s) e_fwd[2*i +: 2] = 2'd2;
                end
                e_mm  = xm_memwrite && mw_regwrite && mw_rd != 0 && mw_rd == xm_rt;
                hz    = model_ldu();
                e_frz = dcache_stall;
                e_bdx = !dcache_stall && hz;
                e_bfd = !dcache_stall && !hz && icache_stall;
            end
            check("fwd_sel",   32'(fwd_sel),   32'(e_fwd));
            check("fwd_mm",    32'(fwd_mm),    32'(e_mm));
            check("freeze",    32'(freeze),    32'(e_frz));
            check("bubble_dx", 32'(bubble_dx), 32'(e_bdx));
            check("bubble_fd", 32'(bubble_fd), 32'(e_bfd));
            check("stall_fd",  32'(stall_fd),  32'(e_bdx | e_bfd));
            check("state",     32'(state),     m_state);
            check("miss_err",  32'(miss_err),  32'(m_err));
            check("ldu_cnt",   32'(ldu_cnt),   m_ldu);
            check("dmiss_cnt", 32'(dmiss_cnt), m_dmiss);
            check("imiss_cnt", 32'(imiss_cnt), m_imiss);
        end
    end

    task automatic clear_in();
        fd_src = '0; dx_src = '0; fd_src_vld = '0; fd_src_mm_ok = '0;
        dx_rd = '0; xm_rd = '0; xm_rt = '0; mw_rd = '0;
        dx_memread = 0; xm_regwrite = 0; xm_memwrite = 0; mw_regwrite = 0;
        dcache_stall = 0; icache_stall = 0;
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(1);
        rst_n = 1;
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        step(1);
        cmp_en = 1;
        dcache_stall = 1; icache_stall = 1;
        settle();
        check("rst freeze forced", 32'(freeze), 0);
        check("rst stall_fd forced", 32'(stall_fd), 0);
        step(1);
        check("rst state", 32'(state), 0);
        check("rst miss_err", 32'(miss_err), 0);
        clear_in();
        rst_n = 1;
        step(1);

        dx_src[0 +: REG_W] = 3; xm_rd = 3; xm_regwrite = 1; mw_rd = 3; mw_regwrite = 1;
        settle(); check("fwd exmem", 32'(fwd_sel[1:0]), 32'h1);
        step(1); xm_regwrite = 0;
        settle(); check("fwd memwb", 32'(fwd_sel[1:0]), 32'h2);
        step(1); xm_regwrite = 1; xm_rd = 0; mw_rd = 0;
        settle(); check("fwd r0", 32'(fwd_sel[1:0]), 32'h0);
        step(1); clear_in();

        xm_memwrite = 1; xm_rt = 7; mw_regwrite = 1; mw_rd = 7;
        settle(); check("fwd_mm hit", 32'(fwd_mm), 1);
        step(1); mw_rd = 0;
        settle(); check("fwd_mm r0", 32'(fwd_mm), 0);
        step(1); clear_in();

        dx_memread = 1; dx_rd = 5; fd_src[REG_W +: REG_W] = 5; fd_src_vld[1] = 1;
        settle();
        check("ldu stall_fd", 32'(stall_fd), 1);
        check("ldu bubble_dx", 32'(bubble_dx), 1);
        step(1); dx_memread = 0;
        settle();
        check("ldu state", 32'(state), 1);
        check("ldu one cycle", 32'(stall_fd), 0);
        step(1); dx_memread = 1; fd_src_mm_ok[1] = 1;
        settle(); check("ldu mm_ok", 32'(stall_fd), 0);
        step(1); clear_in();

        do_reset();
        dx_memread = 1; dx_rd = 5; fd_src[REG_W +: REG_W] = 5; fd_src_vld[1] = 1; dcache_stall = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("frz freeze", 32'(freeze), 1);
            check("frz no bubble", 32'(bubble_dx), 0);
            step(1);
        end
        dcache_stall = 0;
        settle();
        check("post-frz bubble", 32'(bubble_dx), 1);
        check("post-frz state", 32'(state), 2);
        step(1); clear_in();
        settle();
        check("post-frz ldu state", 32'(state), 1);
        check("dmiss_cnt lit", 32'(dmiss_cnt), PERF ? 4 : 0);
        check("ldu_cnt lit", 32'(ldu_cnt), PERF ? 1 : 0);
        step(1);

        icache_stall = 1;
        settle();
        check("imiss stall_fd", 32'(stall_fd), 1);
        check("imiss bubble_fd", 32'(bubble_fd), 1);
        check("imiss bubble_dx", 32'(bubble_dx), 0);
        step(1); icache_stall = 0;
        settle(); check("imiss state", 32'(state), 3);
        step(1);

        do_reset();
        dcache_stall = 1;
        step(7); settle(); check("wd 7 edges", 32'(miss_err), 0);
        step(1); settle(); check("wd 8 edges", 32'(miss_err), 1);
        step(3); dcache_stall = 0;
        step(2); settle(); check("wd sticky", 32'(miss_err), 1);
        do_reset();
        settle();
        check("wd reset err", 32'(miss_err), 0);
        check("wd reset state", 32'(state), 0);

        dcache_stall = 1;
        step(2); rst_n = 0;
        step(1); settle(); check("midmiss rst state", 32'(state), 0);
        rst_n = 1;
        step(1); settle(); check("midmiss reenter", 32'(state), 2);
        clear_in();
        step(1);

        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fd_src[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
                dx_src[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
            end
            fd_src_vld   = NUM_SRC'($urandom);
            fd_src_mm_ok = NUM_SRC'($urandom);
            dx_rd = REG_W'($urandom_range(0, 3)); xm_rd = REG_W'($urandom_range(0, 3));
            xm_rt = REG_W'($urandom_range(0, 3)); mw_rd = REG_W'($urandom_range(0, 3));
            dx_memread  = 1'($urandom); xm_regwrite = 1'($urandom);
            xm_memwrite = 1'($urandom); mw_regwrite = 1'($urandom);
            dcache_stall = ($urandom_range(0, 4) == 0);
            icache_stall = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 60) != 0);
            step(1);
        end
        rst_n = 1; clear_in();
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline with I-cache and D-cache. It generalises operand forwarding to NUM_SRC source operands and adds a stall state machine for load-use hazards, D-cache misses and I-cache misses, plus a miss watchdog. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the EX operand muxes, the MEM store-data mux, and the hold and bubble controls of the pipeline registers.

## Interface
Parameters:
- REG_W, 4, register-address width; register 0 is hardwired zero and is never a forwarding source.
- NUM_SRC, 2, source operands per instruction (2..4); source i occupies bits [i*REG_W +: REG_W].
- CNT_W, 16, width of the watchdog counter and the performance counters.
- MISS_TIMEOUT, 1000, maximum number of consecutive D-miss cycles before `miss_err` is set.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; one clock; synchronous, active-low
- fd_src  in  NUM_SRC*REG_W  IF/ID source registers
- fd_src_vld  in  NUM_SRC  source i is actually read
- fd_src_mm_ok  in  NUM_SRC  source i is store data only (can be satisfied by MEM-to-MEM forwarding)
- dx_src  in  NUM_SRC*REG_W  ID/EX source registers
- dx_rd  in  REG_W  ID/EX destination
- dx_memread  in  1  ID/EX instruction is a load
- xm_rd, xm_rt  in  REG_W each  EX/MEM destination and store-data register
- xm_regwrite, xm_memwrite  in  1 each
- mw_rd  in  REG_W  MEM/WB destination
- mw_regwrite  in  1
- dcache_stall  in  1  D-cache miss in progress
- icache_stall  in  1  I-cache miss in progress
- fwd_sel  out  2*NUM_SRC  per source: 00 register file, 01 EX/MEM, 10 MEM/WB
- fwd_mm  out  1  MEM/WB result goes to the store data in MEM
- freeze  out  1  hold every pipeline register and the PC
- stall_fd  out  1  hold the PC and IF/ID
- bubble_dx  out  1  load a NOP into ID/EX
- bubble_fd  out  1  load a NOP into IF/ID
- state  out  2  00 RUN, 01 LDUSE, 10 DMISS, 11 IMISS
- miss_err  out  1  sticky watchdog flag
- ldu_cnt, dmiss_cnt, imiss_cnt  out  CNT_W each  performance counters

## Operation
- **Forwarding** (per source i, combinational): let s = dx_src[i].
  - fwd_sel = 01 if xm_regwrite & xm_rd!=0 & xm_rd==s.
  - Otherwise fwd_sel = 10 if mw_regwrite & mw_rd!=0 & mw_rd==s.
  - Otherwise fwd_sel = 00.
  - EX/MEM has priority over MEM/WB.
- **MEM-to-MEM**: fwd_mm = xm_memwrite & mw_regwrite & mw_rd!=0 & mw_rd==xm_rt.
- **Load-use hazard** ldu: dx_memread & dx_rd!=0 & (there exists i with fd_src_vld[i] & ~fd_src_mm_ok[i] & fd_src[i]==dx_rd).
- **Priority**: dcache_stall > ldu > icache_stall.
- **Control outputs**:
  - freeze = dcache_stall.
  - When not frozen and ldu: stall_fd=1, bubble_dx=1.
  - When not frozen, no ldu, and icache_stall: stall_fd=1, bubble_fd=1.
  - All other cases: these outputs are 0.
- **FSM**, next state evaluated each edge with the same priority:
  - DMISS if dcache_stall.
  - Otherwise LDUSE if ldu.
  - Otherwise IMISS if icache_stall.
  - Otherwise RUN.
  - The state records the cause of the previous cycle's stall. Control outputs never depend on the state.
- **Watchdog**:
  - The counter increments each cycle that dcache_stall=1 and clears when dcache_stall=0.
  - When the counter reaches MISS_TIMEOUT, miss_err is set. miss_err stays set until reset.
  - The counter saturates at MISS_TIMEOUT.
- **Simultaneous events**: if a ldu hazard exists while frozen, the hazard stays pending and is acted on in the first unfrozen cycle. No bubble is inserted during freeze.

## Timing
- fwd_sel, fwd_mm, freeze, stall_fd, bubble_dx, bubble_fd are combinational, with zero-cycle latency from their inputs.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in EX/MEM and the consumer gets fwd_sel=10 one cycle later.
- state, miss_err and the counters update on the rising clk edge.
- **While rst_n=0**:
  - All combinational control outputs are forced to 0.
  - At the edge: state=RUN, watchdog=0, miss_err=0, all counters=0.
- **Reset mid-miss**: the state returns to RUN, and a still-asserted dcache_stall re-enters DMISS on the first edge after release.

## Configuration
- **HAZARD_PERF_CNT_EN defined**:
  - ldu_cnt, dmiss_cnt and imiss_cnt each count the cycles in which the next state is LDUSE, DMISS or IMISS respectively.
  - The counters saturate at all-ones and clear on reset.
- **Not defined**: the counter ports remain and are tied to 0, and no counter flops are built.

## Test plan
- dx_src[0]=3, xm_rd=3/xm_regwrite=1, mw_rd=3/mw_regwrite=1 -> fwd_sel[1:0]=01. Same with xm_regwrite=0 -> 10. Same with rd=0 -> 00.
- dx_memread=1, dx_rd=5, fd_src[1]=5 valid, mm_ok=0 -> stall_fd=1, bubble_dx=1 for 1 cycle, state=LDUSE. Same with mm_ok=1 -> no stall.
- dcache_stall held 4 cycles together with a ldu hazard -> freeze=1 for 4 cycles with bubble_dx=0, then a 1-cycle bubble. dmiss_cnt=4, ldu_cnt=1 (with HAZARD_PERF_CNT_EN).
- xm_memwrite=1, xm_rt=7, mw_regwrite=1, mw_rd=7 -> fwd_mm=1. Same with mw_rd=0 -> fwd_mm=0.
- MISS_TIMEOUT=8, dcache_stall held 8 cycles -> miss_err=1 after the 8th edge and stays 1 after the stall ends. rst_n=0 for one edge -> miss_err=0, state=00.
- icache_stall=1 with no other hazard -> stall_fd=1, bubble_fd=1, bubble_dx=0, state=IMISS.
